// File: rtl/skew_pkg.sv
// Shared types for the skew monitor: window FSM states and the default counter width.
package skew_pkg;

   localparam int CNT_W_DEF = 8;

   typedef logic [CNT_W_DEF-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      COLLECT,
      REPORT
   } state_t;

endpackage

// File: rtl/skew_monitor_edge_rise.sv
// Vector rising-edge detector; history resets high so levels already asserted at reset release are ignored.
module edge_rise #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] sig_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q <= '1;
      end else begin
         prev_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/skew_monitor.sv
// Cycle-accurate arrival-skew monitor: opens a window on the first strobe edge, times the rest,
// and reports skew, per-channel offsets and a violation flag once per window.
module skew_monitor
   import skew_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [N_CH-1:0]       sig_in,
   input  logic [CNT_W-1:0]      max_skew,
   output logic                  result_valid,
   output logic [CNT_W-1:0]      skew_cycles,
   output logic                  violation,
   output logic [N_CH-1:0]       missing_mask,
   output logic [N_CH*CNT_W-1:0] arr_time
);

   typedef logic [CNT_W-1:0] count_t;
   localparam count_t TIMEOUT_C = count_t'(TIMEOUT);

   state_t          state_q, state_d;
   count_t          cnt_q, cnt_d;
   count_t          last_q, last_d;
   count_t          maxSkew_q, maxSkew_d;
   logic [N_CH-1:0] arrived_q, arrived_d;
   count_t          work_q [N_CH];
   count_t          work_d [N_CH];
   logic [N_CH-1:0] rise;
   logic            goReport;
   logic            timedOut;

   logic                  validOut_q;
   count_t                skewOut_q, skewOut_d;
   logic                  violOut_q, violOut_d;
   logic [N_CH-1:0]       missOut_q, missOut_d;
   logic [N_CH*CNT_W-1:0] arrOut_q, arrOut_d;

   edge_rise #(.W(N_CH)) uEdgeRise (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (sig_in),
      .rise_o (rise)
   );

   // Window sequencing: goReport marks the cycle whose edges complete (or time out) the window.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      maxSkew_d = maxSkew_q;
      arrived_d = arrived_q;
      work_d    = work_q;
      goReport  = 1'b0;
      timedOut  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en) state_d = ARMED;
         end
         ARMED: begin
            if (!en) begin
               state_d = IDLE;
            end else if (|rise) begin
               maxSkew_d = max_skew;
               arrived_d = rise;
               last_d    = '0;
               cnt_d     = count_t'(1);
               for (int i = 0; i < N_CH; i++) begin
                  if (rise[i]) work_d[i] = '0;
               end
               if (&rise) begin
                  state_d  = REPORT;
                  goReport = 1'b1;
               end else begin
                  state_d = COLLECT;
               end
            end
         end
         COLLECT: begin
            if (!en) begin
               state_d   = IDLE;
               arrived_d = '0;
               cnt_d     = '0;
               last_d    = '0;
            end else begin
               for (int i = 0; i < N_CH; i++) begin
                  if (rise[i] && !arrived_q[i]) begin
                     work_d[i] = cnt_q;
                     last_d    = cnt_q;
                  end
               end
               arrived_d = arrived_q | rise;
               if (&arrived_d) begin
                  state_d  = REPORT;
                  goReport = 1'b1;
               end else if (cnt_q == TIMEOUT_C) begin
                  state_d  = REPORT;
                  goReport = 1'b1;
                  timedOut = 1'b1;
               end else begin
                  cnt_d = cnt_q + count_t'(1);
               end
            end
         end
         REPORT: begin
            state_d   = en ? ARMED : IDLE;
            arrived_d = '0;
            cnt_d     = '0;
            last_d    = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Report values are computed from next-state so they land in the same cycle as result_valid.
   always_comb begin
      skewOut_d = timedOut ? TIMEOUT_C : last_d;
      missOut_d = ~arrived_d;
      violOut_d = (skewOut_d > maxSkew_d) | (|missOut_d);
      arrOut_d  = '0;
      for (int i = 0; i < N_CH; i++) begin
         arrOut_d[i*CNT_W +: CNT_W] = arrived_d[i] ? work_d[i] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= '0;
         maxSkew_q  <= '0;
         arrived_q  <= '0;
         for (int i = 0; i < N_CH; i++) work_q[i] <= '0;
         validOut_q <= 1'b0;
         skewOut_q  <= '0;
         violOut_q  <= 1'b0;
         missOut_q  <= '0;
         arrOut_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         maxSkew_q  <= maxSkew_d;
         arrived_q  <= arrived_d;
         for (int i = 0; i < N_CH; i++) work_q[i] <= work_d[i];
         validOut_q <= goReport;
         if (goReport) begin
            skewOut_q <= skewOut_d;
            violOut_q <= violOut_d;
            missOut_q <= missOut_d;
            arrOut_q  <= arrOut_d;
         end
      end
   end

   assign result_valid = validOut_q;
   assign skew_cycles  = skewOut_q;
   assign violation    = violOut_q;
   assign missing_mask = missOut_q;
   assign arr_time     = arrOut_q;

endmodule

// File: tb/tb_skew_monitor.sv
// Directed bench for skew_monitor: an event-time model tracks absolute edge cycles per window
// and is compared every cycle, alongside literal checks of hand-worked windows.
module tb_skew_monitor;

   localparam int N_CH    = 4;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 32;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  en;
   logic [N_CH-1:0]       sig_in;
   logic [CNT_W-1:0]      max_skew;
   logic                  result_valid;
   logic [CNT_W-1:0]      skew_cycles;
   logic                  violation;
   logic [N_CH-1:0]       missing_mask;
   logic [N_CH*CNT_W-1:0] arr_time;

   int nVectors    = 0;
   int nMiscompare = 0;

   skew_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .sig_in       (sig_in),
      .max_skew     (max_skew),
      .result_valid (result_valid),
      .skew_cycles  (skew_cycles),
      .violation    (violation),
      .missing_mask (missing_mask),
      .arr_time     (arr_time)
   );

   always #5 clk = ~clk;

   // Every comparison funnels through here so both counters stay authoritative.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompare++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [N_CH-1:0] s);
      sig_in = s;
      tick();
   endtask

   task automatic quiesce();
      sig_in = '0;
      repeat (3) tick();
   endtask

   task automatic waitReport(input int limit, output int n);
      n = 0;
      while (!result_valid && n < limit) begin
         tick();
         n++;
      end
   endtask

   // Model: window state in absolute cycle numbers; the skew is the spread of first-edge times.
   int              cyc = 0;
   int              phase = 0;
   int              firstCyc;
   int              thr;
   int              arrCyc [N_CH];
   logic [N_CH-1:0] prevSig = '1;
   logic [N_CH-1:0] edges;
   bit              done, tmo;
   int              spread;
   logic                  expValid = 1'b0;
   logic [CNT_W-1:0]      expSkew = '0;
   logic                  expViol = 1'b0;
   logic [N_CH-1:0]       expMiss = '0;
   logic [N_CH*CNT_W-1:0] expArr = '0;
   bit                    checkOn = 1'b0;

   always @(posedge clk) begin
      cyc++;
      expValid = 1'b0;
      if (!rst_n) begin
         phase   = 0;
         prevSig = '1;
         expSkew = '0;
         expViol = 1'b0;
         expMiss = '0;
         expArr  = '0;
         for (int i = 0; i < N_CH; i++) arrCyc[i] = -1;
         checkOn = 1'b1;
      end else begin
         edges = sig_in & ~prevSig;
         done  = 1'b0;
         tmo   = 1'b0;
         case (phase)
            0: if (en) phase = 1;
            1: begin
               if (!en) phase = 0;
               else if (edges != '0) begin
                  firstCyc = cyc;
                  thr      = int'(max_skew);
                  for (int i = 0; i < N_CH; i++) arrCyc[i] = edges[i] ? cyc : -1;
                  done  = (edges == '1);
                  phase = 2;
               end
            end
            2: begin
               if (!en) phase = 0;
               else begin
                  done = 1'b1;
                  for (int i = 0; i < N_CH; i++) begin
                     if (edges[i] && arrCyc[i] < 0) arrCyc[i] = cyc;
                     if (arrCyc[i] < 0) done = 1'b0;
                  end
                  if (!done && (cyc - firstCyc) == TIMEOUT) begin
                     done = 1'b1;
                     tmo  = 1'b1;
                  end
               end
            end
            default: phase = en ? 1 : 0;
         endcase
         if (done) begin
            phase    = 3;
            expValid = 1'b1;
            spread   = 0;
            expArr   = '0;
            for (int i = 0; i < N_CH; i++) begin
               expMiss[i] = (arrCyc[i] < 0);
               if (arrCyc[i] >= 0) begin
                  expArr[i*CNT_W +: CNT_W] = CNT_W'(arrCyc[i] - firstCyc);
                  if (arrCyc[i] - firstCyc > spread) spread = arrCyc[i] - firstCyc;
               end
            end
            if (tmo) spread = TIMEOUT;
            expSkew = CNT_W'(spread);
            expViol = (spread > thr) || (expMiss != '0);
         end
         prevSig = sig_in;
      end
   end

   always @(posedge clk) begin
      #1;
      if (checkOn) begin
         checkOutput("model result_valid", 64'(result_valid), 64'(expValid));
         checkOutput("model skew_cycles", 64'(skew_cycles), 64'(expSkew));
         checkOutput("model violation", 64'(violation), 64'(expViol));
         checkOutput("model missing_mask", 64'(missing_mask), 64'(expMiss));
         checkOutput("model arr_time", 64'(arr_time), 64'(expArr));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int pulses;

      rst_n    = 1'b0;
      en       = 1'b1;
      sig_in   = '1;
      max_skew = 8'd2;
      repeat (3) tick();
      checkOutput("reset result_valid", 64'(result_valid), 64'd0);
      checkOutput("reset arr_time", 64'(arr_time), 64'd0);

      // Levels high across reset release must not open a window.
      rst_n  = 1'b1;
      pulses = 0;
      repeat (40) begin
         tick();
         if (result_valid) pulses++;
      end
      checkOutput("held-high no report", 64'(pulses), 64'd0);
      checkOutput("held-high skew", 64'(skew_cycles), 64'd0);

      quiesce();
      applyStimulus(4'b0001);
      applyStimulus(4'b0011);
      applyStimulus(4'b1111);
      checkOutput("staggered valid", 64'(result_valid), 64'd1);
      checkOutput("staggered skew", 64'(skew_cycles), 64'd2);
      checkOutput("staggered arr_time", 64'(arr_time), 64'h02020100);
      checkOutput("staggered violation", 64'(violation), 64'd0);
      checkOutput("staggered missing", 64'(missing_mask), 64'd0);

      quiesce();
      applyStimulus(4'b0001);
      tick();
      tick();
      applyStimulus(4'b1111);
      checkOutput("over-threshold valid", 64'(result_valid), 64'd1);
      checkOutput("over-threshold skew", 64'(skew_cycles), 64'd3);
      checkOutput("over-threshold violation", 64'(violation), 64'd1);
      checkOutput("over-threshold arr_time", 64'(arr_time), 64'h03030300);

      quiesce();
      applyStimulus(4'b0001);
      applyStimulus(4'b0101);
      waitReport(40, n);
      checkOutput("timeout latency", 64'(n), 64'd31);
      checkOutput("timeout skew", 64'(skew_cycles), 64'd32);
      checkOutput("timeout missing", 64'(missing_mask), 64'b1010);
      checkOutput("timeout violation", 64'(violation), 64'd1);
      checkOutput("timeout arr_time", 64'(arr_time), 64'h00010000);

      quiesce();
      applyStimulus(4'b1111);
      checkOutput("simultaneous valid", 64'(result_valid), 64'd1);
      checkOutput("simultaneous skew", 64'(skew_cycles), 64'd0);
      checkOutput("simultaneous violation", 64'(violation), 64'd0);
      applyStimulus(4'b0000);
      applyStimulus(4'b1100);
      max_skew = 8'd0;
      applyStimulus(4'b1100);
      applyStimulus(4'b1111);
      checkOutput("back-to-back valid", 64'(result_valid), 64'd1);
      checkOutput("back-to-back skew", 64'(skew_cycles), 64'd2);
      checkOutput("equal-threshold violation", 64'(violation), 64'd0);
      checkOutput("back-to-back arr_time", 64'(arr_time), 64'h00000202);

      max_skew = 8'd2;
      quiesce();
      applyStimulus(4'b0001);
      tick();
      en = 1'b0;
      pulses = 0;
      sig_in = 4'b1111;
      repeat (6) begin
         tick();
         if (result_valid) pulses++;
      end
      checkOutput("abort en no report", 64'(pulses), 64'd0);
      checkOutput("abort en held skew", 64'(skew_cycles), 64'd2);
      checkOutput("abort en held arr_time", 64'(arr_time), 64'h00000202);
      en = 1'b1;

      quiesce();
      applyStimulus(4'b0001);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("abort reset valid", 64'(result_valid), 64'd0);
      checkOutput("abort reset skew", 64'(skew_cycles), 64'd0);
      checkOutput("abort reset arr_time", 64'(arr_time), 64'd0);
      quiesce();
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompare);
      $finish;
   end

endmodule
